// File: rtl/clk_gen_downsampler.sv
// clk_gen_downsampler: programmable 50%-duty divider for the ring-oscillator clock.
// The output period is 2*(div+1) clk_i cycles. A new divide value is taken
// through a valid/ready handshake. It is applied only at a period boundary,
// or at once while the output is parked low.
module clk_gen_downsampler #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] val_i,
  input  logic               val_v_i,
  output logic               val_ready_o,
  output logic               clk_r_o,
  output logic [width_p-1:0] div_o
);

  localparam logic [width_p-1:0] one_c = {{(width_p-1){1'b0}}, 1'b1};

  logic [width_p-1:0] ctr_r;
  logic [width_p-1:0] ctr_next;
  logic [width_p-1:0] div_r;
  logic [width_p-1:0] div_next;
  logic [width_p-1:0] pend_r;
  logic [width_p-1:0] pend_next;
  logic               pend_v_r;
  logic               pend_v_next;
  logic               clk_next;

  logic               tc;
  logic               running;
  logic               accept;

  // Terminal count ends a phase. A high phase always runs to completion,
  // even after en_i drops, so the output never produces a runt pulse.
  assign tc          = (ctr_r == '0);
  assign running     = en_i | clk_r_o;
  assign accept      = val_v_i & ~pend_v_r;
  assign val_ready_o = ~pend_v_r;
  assign div_o       = div_r;

  // State register. clk_r_o comes straight from this flop, so the output is glitch-free.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctr_r    <= '0;
      div_r    <= '0;
      pend_r   <= '0;
      pend_v_r <= 1'b0;
      clk_r_o  <= 1'b0;
    end else begin
      ctr_r    <= ctr_next;
      div_r    <= div_next;
      pend_r   <= pend_next;
      pend_v_r <= pend_v_next;
      clk_r_o  <= clk_next;
    end
  end

  // Next-state logic. It handles counting, phase toggling, the boundary
  // reload and the handshake capture.
  always_comb begin
    ctr_next    = ctr_r;
    div_next    = div_r;
    pend_next   = pend_r;
    pend_v_next = pend_v_r;
    clk_next    = clk_r_o;

    if (running) begin
      if (!tc) begin
        ctr_next = ctr_r - one_c;
      end else if (!clk_r_o) begin
        // End of the low phase: start the high phase with the same divide.
        clk_next = 1'b1;
        ctr_next = div_r;
      end else begin
        // End of the high phase: this is the period boundary, where a pending value may be applied.
        clk_next = 1'b0;
        if (pend_v_r) begin
          div_next    = pend_r;
          ctr_next    = pend_r;
          pend_v_next = 1'b0;
        end else begin
          ctr_next = div_r;
        end
      end
    end else if (pend_v_r) begin
      // Parked low: no period is in progress, so a pending value applies at once.
      div_next    = pend_r;
      ctr_next    = pend_r;
      pend_v_next = 1'b0;
    end

    // Capture only happens while nothing is pending. It therefore never
    // collides with an apply in the same cycle.
    if (accept) begin
      pend_next   = val_i;
      pend_v_next = 1'b1;
    end
  end

endmodule
